// File: rtl/captura_palabra_fpga_pkg.sv
// Shared definitions for the keyed word-entry path: FSM encoding, word sizing, key levels.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package captura_palabra_fpga_pkg;

    // CAPTURA: accepting nibbles. ENTREGA: holding a finished word until the consumer takes it.
    typedef enum logic {
        CAPTURA = 1'b0,
        ENTREGA = 1'b1
    } estado_t;

    localparam int NIBBLES_DEF = 8;
    localparam int DATA_W_DEF  = 4 * NIBBLES_DEF;

    // Pushbuttons are active-low, so the idle (released) level is 1.
    localparam logic TECLA_SUELTA = 1'b1;

    // Width of the nibble counter; never below one bit.
    function automatic int ancho_cuenta(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction

endpackage

// File: rtl/captura_palabra_fpga_antirrebote.sv
// Purpose: synchronize an async active-low key, debounce it, emit a one-cycle pulse on each press.
// Latency: key steady -> pulso_o after 2 sync + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; the pulse is fire-and-forget.
//
// Ports:
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   key_ni   raw pushbutton, active-low, asynchronous, bouncy
//   nivel_o  debounced key level (1 = released)
//   pulso_o  one-cycle pulse per accepted press
module antirrebote
    import captura_palabra_fpga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic nivel_o,
    output logic pulso_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             nivel_q, nivel_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulso_q, pulso_d;
    logic [1:0]       vld_q;
    logic             armado_q;

    // The count reaching DEBOUNCE_CYCLES is detected one step early so the
    // level flips after exactly DEBOUNCE_CYCLES differing cycles.
    always_comb begin
        nivel_d = nivel_q;
        cnt_d   = '0;
        if (s2_q != nivel_q) begin
            if (cnt_q == CNT_FIN) begin
                nivel_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        // A press only counts once the key has been seen released after reset,
        // so a button held through reset does not fire on its own.
        pulso_d = armado_q & nivel_q & ~nivel_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q     <= TECLA_SUELTA;
            s2_q     <= TECLA_SUELTA;
            nivel_q  <= TECLA_SUELTA;
            cnt_q    <= '0;
            pulso_q  <= 1'b0;
            vld_q    <= 2'b00;
            armado_q <= 1'b0;
        end else begin
            s1_q     <= key_ni;
            s2_q     <= s1_q;
            nivel_q  <= nivel_d;
            cnt_q    <= cnt_d;
            pulso_q  <= pulso_d;
            // vld_q[1] marks that s2_q now carries a real sample, not the reset value.
            vld_q    <= {vld_q[0], 1'b1};
            armado_q <= armado_q | (vld_q[1] & s2_q);
        end
    end

    assign nivel_o = nivel_q;
    assign pulso_o = pulso_q;

endmodule

// File: rtl/captura_palabra_fpga.sv
// Purpose: operator keys a word one hex nibble at a time (switches + LOAD, CLR aborts); word offered on valid/ready.
// Latency: LOAD pulse -> parcial_o/valido_o update in 1 cycle; press-to-pulse 2 + DEBOUNCE_CYCLES + 1.
// Backpressure: finished word held on dato_o with valido_o=1 until listo_i; LOAD ignored meanwhile.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   sw_i                 nibble switches (async)
//   key_load_ni/clr_ni   LOAD / CLR pushbuttons (active-low, async, bouncy)
//   listo_i              consumer ready
//   dato_o, valido_o     completed word and its valid flag
//   parcial_o, cuenta_o  shift register contents and nibble count for the display
module captura_palabra_fpga
    import captura_palabra_fpga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NIBBLES         = NIBBLES_DEF,
    localparam int DATA_W         = 4 * NIBBLES,
    localparam int CW             = ancho_cuenta(NIBBLES)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [3:0]        sw_i,
    input  logic              key_load_ni,
    input  logic              key_clr_ni,
    input  logic              listo_i,
    output logic [DATA_W-1:0] dato_o,
    output logic              valido_o,
    output logic [DATA_W-1:0] parcial_o,
    output logic [CW-1:0]     cuenta_o
);

    localparam logic [CW-1:0] ULTIMO = CW'(NIBBLES - 1);

    logic              pulso_load, pulso_clr;
    logic [3:0]        sw_s1_q, sw_s2_q;

    estado_t           estado_q, estado_d;
    logic [DATA_W-1:0] parcial_q, parcial_d, parcial_sh;
    logic [DATA_W-1:0] dato_q, dato_d;
    logic [CW-1:0]     cuenta_q, cuenta_d;
    logic              valido_q, valido_d;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_load (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .key_ni  (key_load_ni),
        .nivel_o (),
        .pulso_o (pulso_load)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ar_clr (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .key_ni  (key_clr_ni),
        .nivel_o (),
        .pulso_o (pulso_clr)
    );

    // Switches are read only on a LOAD pulse, long after they settle, so a
    // plain 2-flop synchronizer per bit is enough.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    // Priority: CLR > handshake > LOAD. The handshake only exists in ENTREGA
    // and LOAD only acts in CAPTURA, so a LOAD in CAPTURA is never dropped.
    always_comb begin
        estado_d   = estado_q;
        parcial_d  = parcial_q;
        dato_d     = dato_q;
        cuenta_d   = cuenta_q;
        valido_d   = valido_q;
        parcial_sh = {parcial_q[DATA_W-5:0], sw_s2_q};

        if (pulso_clr) begin
            parcial_d = '0;
            cuenta_d  = '0;
            valido_d  = 1'b0;
            estado_d  = CAPTURA;
        end else begin
            case (estado_q)
                CAPTURA: begin
                    if (pulso_load) begin
                        parcial_d = parcial_sh;
                        if (cuenta_q == ULTIMO) begin
                            dato_d   = parcial_sh;
                            valido_d = 1'b1;
                            cuenta_d = '0;
                            estado_d = ENTREGA;
                        end else begin
                            cuenta_d = cuenta_q + 1'b1;
                        end
                    end
                end
                ENTREGA: begin
                    if (valido_q && listo_i) begin
                        valido_d  = 1'b0;
                        parcial_d = '0;
                        estado_d  = CAPTURA;
                    end
                end
                default: estado_d = CAPTURA;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            estado_q  <= CAPTURA;
            parcial_q <= '0;
            dato_q    <= '0;
            cuenta_q  <= '0;
            valido_q  <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            parcial_q <= parcial_d;
            dato_q    <= dato_d;
            cuenta_q  <= cuenta_d;
            valido_q  <= valido_d;
        end
    end

    assign dato_o    = dato_q;
    assign valido_o  = valido_q;
    assign parcial_o = parcial_q;
    assign cuenta_o  = cuenta_q;

endmodule

// File: tb/tb_captura_palabra_fpga.sv
// Directed bench for captura_palabra_fpga with a short debounce window.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Summary line reports total checks and errors.
module tb_captura_palabra_fpga;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  sw_i = 4'h0;
    logic        key_load_ni = 1'b1;
    logic        key_clr_ni = 1'b1;
    logic        listo_i = 1'b0;
    logic [31:0] dato_o;
    logic        valido_o;
    logic [31:0] parcial_o;
    logic [2:0]  cuenta_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    captura_palabra_fpga #(.DEBOUNCE_CYCLES(4), .NIBBLES(8)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .sw_i        (sw_i),
        .key_load_ni (key_load_ni),
        .key_clr_ni  (key_clr_ni),
        .listo_i     (listo_i),
        .dato_o      (dato_o),
        .valido_o    (valido_o),
        .parcial_o   (parcial_o),
        .cuenta_o    (cuenta_o)
    );

    typedef struct {
        logic [3:0]  sw;
        logic [2:0]  cuenta;
        logic [31:0] parcial;
        logic        valido;
    } vec_t;

    vec_t tabla [8];

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nombre, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // Clean press: held low well past the debounce window, then released long
    // enough for the debounced level to return high.
    task automatic pulsar(input logic [3:0] nib, input logic load, input logic clr);
        sw_i        = nib;
        key_load_ni = ~load;
        key_clr_ni  = ~clr;
        cyc(10);
        key_load_ni = 1'b1;
        key_clr_ni  = 1'b1;
        cyc(10);
    endtask

    task automatic entregar();
        listo_i = 1'b1;
        cyc(1);
        listo_i = 1'b0;
    endtask

    initial begin
        tabla[0] = '{sw: 4'h1, cuenta: 3'd1, parcial: 32'h0000_0001, valido: 1'b0};
        tabla[1] = '{sw: 4'h2, cuenta: 3'd2, parcial: 32'h0000_0012, valido: 1'b0};
        tabla[2] = '{sw: 4'h3, cuenta: 3'd3, parcial: 32'h0000_0123, valido: 1'b0};
        tabla[3] = '{sw: 4'h4, cuenta: 3'd4, parcial: 32'h0000_1234, valido: 1'b0};
        tabla[4] = '{sw: 4'h5, cuenta: 3'd5, parcial: 32'h0001_2345, valido: 1'b0};
        tabla[5] = '{sw: 4'h6, cuenta: 3'd6, parcial: 32'h0012_3456, valido: 1'b0};
        tabla[6] = '{sw: 4'h7, cuenta: 3'd7, parcial: 32'h0123_4567, valido: 1'b0};
        tabla[7] = '{sw: 4'h8, cuenta: 3'd0, parcial: 32'h1234_5678, valido: 1'b1};

        // Reset state
        cyc(3);
        chk("reset_dato", dato_o, 32'h0);
        chk("reset_valido", {31'b0, valido_o}, 32'h0);
        chk("reset_parcial", parcial_o, 32'h0);
        chk("reset_cuenta", {29'b0, cuenta_o}, 32'h0);
        rst_ni = 1'b1;
        cyc(5);

        // Full entry, table driven
        for (int i = 0; i < 8; i++) begin
            pulsar(tabla[i].sw, 1'b1, 1'b0);
            chk($sformatf("entry%0d_cuenta", i), {29'b0, cuenta_o}, {29'b0, tabla[i].cuenta});
            chk($sformatf("entry%0d_parcial", i), parcial_o, tabla[i].parcial);
            chk($sformatf("entry%0d_valido", i), {31'b0, valido_o}, {31'b0, tabla[i].valido});
        end
        chk("entry_dato", dato_o, 32'h1234_5678);

        // Backpressure: presses in ENTREGA are ignored
        for (int i = 0; i < 3; i++) begin
            pulsar(4'hF, 1'b1, 1'b0);
            chk($sformatf("bp%0d_dato", i), dato_o, 32'h1234_5678);
            chk($sformatf("bp%0d_valido", i), {31'b0, valido_o}, 32'h1);
            chk($sformatf("bp%0d_parcial", i), parcial_o, 32'h1234_5678);
            chk($sformatf("bp%0d_cuenta", i), {29'b0, cuenta_o}, 32'h0);
        end
        entregar();
        chk("bp_valido_falls", {31'b0, valido_o}, 32'h0);
        chk("bp_parcial_cleared", parcial_o, 32'h0);
        chk("bp_dato_kept", dato_o, 32'h1234_5678);

        // Bounce: toggling faster than the window yields no pulse
        pulsar(4'hA, 1'b1, 1'b0);
        chk("pre_bounce_cuenta", {29'b0, cuenta_o}, 32'h1);
        sw_i = 4'h3;
        for (int i = 0; i < 5; i++) begin
            key_load_ni = 1'b0;
            cyc(2);
            key_load_ni = 1'b1;
            cyc(2);
        end
        cyc(10);
        chk("bounce_cuenta", {29'b0, cuenta_o}, 32'h1);
        chk("bounce_parcial", parcial_o, 32'h0000_000A);
        pulsar(4'h0, 1'b0, 1'b1);
        chk("bounce_clr_cuenta", {29'b0, cuenta_o}, 32'h0);

        // Clear mid-word
        pulsar(4'hA, 1'b1, 1'b0);
        pulsar(4'hB, 1'b1, 1'b0);
        pulsar(4'hC, 1'b1, 1'b0);
        chk("clr_pre_cuenta", {29'b0, cuenta_o}, 32'h3);
        chk("clr_pre_parcial", parcial_o, 32'h0000_0ABC);
        pulsar(4'h0, 1'b0, 1'b1);
        chk("clr_cuenta", {29'b0, cuenta_o}, 32'h0);
        chk("clr_parcial", parcial_o, 32'h0);
        chk("clr_dato_kept", dato_o, 32'h1234_5678);
        for (int i = 0; i < 8; i++) pulsar(4'(i), 1'b1, 1'b0);
        chk("clr_final_dato", dato_o, 32'h0123_4567);
        chk("clr_final_valido", {31'b0, valido_o}, 32'h1);
        entregar();
        chk("clr_final_handshake", {31'b0, valido_o}, 32'h0);

        // Simultaneous CLR and LOAD on the 8th nibble
        for (int i = 0; i < 7; i++) pulsar(4'h9, 1'b1, 1'b0);
        chk("sim_pre_cuenta", {29'b0, cuenta_o}, 32'h7);
        pulsar(4'h9, 1'b1, 1'b1);
        chk("sim_valido", {31'b0, valido_o}, 32'h0);
        chk("sim_cuenta", {29'b0, cuenta_o}, 32'h0);
        chk("sim_parcial", parcial_o, 32'h0);
        chk("sim_dato_kept", dato_o, 32'h0123_4567);

        // Reset mid-operation, LOAD held through reset
        for (int i = 0; i < 8; i++) pulsar(4'hE, 1'b1, 1'b0);
        chk("rst_pre_valido", {31'b0, valido_o}, 32'h1);
        key_load_ni = 1'b0;
        sw_i = 4'h6;
        cyc(10);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_dato", dato_o, 32'h0);
        chk("rst_async_valido", {31'b0, valido_o}, 32'h0);
        chk("rst_async_parcial", parcial_o, 32'h0);
        chk("rst_async_cuenta", {29'b0, cuenta_o}, 32'h0);
        cyc(3);
        rst_ni = 1'b1;
        cyc(20);
        chk("rst_held_cuenta", {29'b0, cuenta_o}, 32'h0);
        chk("rst_held_parcial", parcial_o, 32'h0);
        key_load_ni = 1'b1;
        cyc(10);
        chk("rst_release_cuenta", {29'b0, cuenta_o}, 32'h0);
        pulsar(4'h5, 1'b1, 1'b0);
        chk("rst_repress_cuenta", {29'b0, cuenta_o}, 32'h1);
        chk("rst_repress_parcial", parcial_o, 32'h0000_0005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
